// File: rtl/uart_pkg.sv
// Shared UART clocking types and default sizing.
// Fractional divide hardware is built only with FRAC_BAUD_FRAC_DIV_EN.
package uart_pkg;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OVS    = 16;

  localparam logic [DEF_DIV_W-1:0] DEF_RESET_DIV = 16'd325;

  typedef logic [DEF_DIV_W-1:0]  div_int_t;
  typedef logic [DEF_FRAC_W-1:0] div_frac_t;

  typedef struct packed {
    div_int_t  d_int;
    div_frac_t d_frac;
  } divisor_t;

endpackage

// File: rtl/frac_baud_accum.sv
// Fractional phase accumulator; carry-out stretches the next
// oversample period by one clock. Used with FRAC_BAUD_FRAC_DIV_EN.
module frac_baud_accum
  import uart_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              tick_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              stretch_o
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_stretch;
  logic [FRAC_W:0]   w_sum;

  assign w_sum     = {1'b0, r_acc} + {1'b0, frac_i};
  assign stretch_o = r_stretch;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (tick_i) begin
      r_acc     <= w_sum[FRAC_W-1:0];
      r_stretch <= w_sum[FRAC_W];
    end
  end

endmodule

// File: rtl/frac_baud_generator.sv
// UART baud/oversample tick generator with shadowed divisor reload.
// Define FRAC_BAUD_FRAC_DIV_EN to enable the fractional divisor.
module frac_baud_generator
  import uart_pkg::*;
#(
  parameter int               DIV_W     = DEF_DIV_W,
  parameter int               FRAC_W    = DEF_FRAC_W,
  parameter int               OVS       = DEF_OVS,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEF_RESET_DIV)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              sync_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  divisor_int_i,
  input  logic [FRAC_W-1:0] divisor_frac_i,
  output logic              ov_tick_o,
  output logic              baud_tick_o,
  output logic              mid_bit_o,
  output logic              div_ack_o
);

  localparam int SUB_W = $clog2(OVS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVS / 2 - 1);

  logic [DIV_W:0]   r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_sh_div;
  logic             r_pend;
  logic             r_rst_q;

  logic             w_run;
  logic             w_wrap;
  logic             w_apply;
  logic             w_stretch;
  logic [DIV_W:0]   w_top;

  // The cycle after reset is a settle cycle: nothing counts or fires.
  assign w_run   = enable_i & ~sync_i & ~rst_i & ~r_rst_q;
  assign w_top   = {1'b0, r_div} + {{DIV_W{1'b0}}, w_stretch};
  assign w_wrap  = w_run & (r_cnt >= w_top);
  assign w_apply = r_pend & ~rst_i & ~r_rst_q & (w_wrap | ~enable_i);

  assign ov_tick_o   = w_wrap;
  assign baud_tick_o = w_wrap & (r_sub == SUB_LAST);
  assign mid_bit_o   = w_wrap & (r_sub == SUB_MID);
  assign div_ack_o   = w_apply;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      if (sync_i) begin
        r_cnt <= '0;
        r_sub <= '0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        if (r_sub == SUB_LAST) r_sub <= '0;
        else r_sub <= r_sub + SUB_W'(1);
      end else if (w_run) begin
        r_cnt <= r_cnt + (DIV_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div    <= RESET_DIV;
      r_sh_div <= RESET_DIV;
      r_pend   <= 1'b0;
    end else begin
      if (w_apply) r_div <= r_sh_div;
      if (div_load_i) begin
        r_sh_div <= divisor_int_i;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

`ifdef FRAC_BAUD_FRAC_DIV_EN
  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] r_sh_frac;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frac    <= '0;
      r_sh_frac <= '0;
    end else begin
      if (w_apply) r_frac <= r_sh_frac;
      if (div_load_i) r_sh_frac <= divisor_frac_i;
    end
  end

  frac_baud_accum #(
    .FRAC_W (FRAC_W)
  ) u_accum (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (sync_i),
    .tick_i    (w_wrap),
    .frac_i    (r_frac),
    .stretch_o (w_stretch)
  );
`else
  logic w_unused_frac;
  assign w_unused_frac = ^divisor_frac_i;
  assign w_stretch     = 1'b0;
`endif

endmodule

// File: tb/tb_frac_baud_generator.sv
// Self-checking bench for frac_baud_generator: directed tables,
// corner sequences and a random run against a cycle-level model.
module tb_frac_baud_generator;
  import uart_pkg::*;

  localparam int DW   = 16;
  localparam int FW   = 4;
  localparam int OV   = 16;
  localparam int RDIV = 325;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          sync_i = 1'b0;
  logic          div_load_i = 1'b0;
  logic [DW-1:0] divisor_int_i = '0;
  logic [FW-1:0] divisor_frac_i = '0;
  logic          ov_tick_o;
  logic          baud_tick_o;
  logic          mid_bit_o;
  logic          div_ack_o;

  frac_baud_generator #(
    .DIV_W     (DW),
    .FRAC_W    (FW),
    .OVS       (OV),
    .RESET_DIV (16'd325)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .sync_i         (sync_i),
    .div_load_i     (div_load_i),
    .divisor_int_i  (divisor_int_i),
    .divisor_frac_i (divisor_frac_i),
    .ov_tick_o      (ov_tick_o),
    .baud_tick_o    (baud_tick_o),
    .mid_bit_o      (mid_bit_o),
    .div_ack_o      (div_ack_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tnow = 0;
  bit s_ov, s_baud, s_mid, s_ack;

  // Reference: period length, tick count since phase start, divisor regs
  int m_D, m_F, m_shD, m_shF, m_pend, m_post;
  int m_pos, m_nt, m_acc, m_extra;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               name, act, exp, tnow);
    end
  endtask

  task automatic model_reset();
    m_D = RDIV; m_F = 0; m_shD = RDIV; m_shF = 0;
    m_pend = 0; m_post = 1;
    m_pos = 0; m_nt = 0; m_acc = 0; m_extra = 0;
  endtask

  task automatic step(input bit rst, input bit en, input bit sy,
                      input bit ld, input int di, input int df);
    bit e_ov, e_baud, e_mid, e_ack, run;
    int f_old;
    @(negedge clk_i);
    rst_i = rst; enable_i = en; sync_i = sy; div_load_i = ld;
    divisor_int_i = DW'(di); divisor_frac_i = FW'(df);
    #1;
    tnow = cyc;
    e_ov = 0; e_baud = 0; e_mid = 0; e_ack = 0; run = 0;
    if (!rst) begin
      run    = en && !sy && (m_post == 0);
      e_ov   = run && (m_pos >= m_D + m_extra);
      e_baud = e_ov && (m_nt == OV - 1);
      e_mid  = e_ov && (m_nt == OV / 2 - 1);
      e_ack  = (m_pend != 0) && (m_post == 0) && (e_ov || !en);
    end
    check("outputs{ov,baud,mid,ack}",
          {28'd0, ov_tick_o, baud_tick_o, mid_bit_o, div_ack_o},
          {28'd0, e_ov, e_baud, e_mid, e_ack});
    s_ov = ov_tick_o; s_baud = baud_tick_o;
    s_mid = mid_bit_o; s_ack = div_ack_o;
    if (rst) begin
      model_reset();
    end else begin
      f_old = m_F;
      m_post = 0;
      if (e_ack) begin m_D = m_shD; m_F = m_shF; end
      if (ld) begin
        m_shD = di; m_shF = df % (1 << FW); m_pend = 1;
      end else if (e_ack) begin
        m_pend = 0;
      end
      if (sy) begin
        m_pos = 0; m_nt = 0; m_acc = 0; m_extra = 0;
      end else if (e_ov) begin
        m_pos = 0;
        m_nt = (m_nt + 1) % OV;
`ifdef FRAC_BAUD_FRAC_DIV_EN
        m_acc = m_acc + f_old;
        m_extra = (m_acc >= (1 << FW)) ? 1 : 0;
        m_acc = m_acc % (1 << FW);
`else
        if (f_old < 0) m_acc = 0;
`endif
      end else if (run) begin
        m_pos++;
      end
    end
    cyc++;
  endtask

  task automatic load_div(input string name, input int d, input int f);
    bit seen;
    seen = 0;
    step(0, 0, 0, 1, d, f);
    for (int i = 0; i < 4 && !seen; i++) begin
      step(0, 0, 0, 0, 0, 0);
      seen = s_ack;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    div_int_t d;
    int       ov_p;
    int       baud_p;
    int       mid_off;
  } vec_t;

  vec_t tbl[4];

  int t_s, t_l, t_p, t1, t2, ta, tb1, tb2, tm, cnt, n_ack;

  initial begin
    tbl[0] = '{16'd3, 4, 64, 32};
    tbl[1] = '{16'd0, 1, 16, 8};
    tbl[2] = '{16'd7, 8, 128, 64};
    tbl[3] = '{16'd1, 2, 32, 16};
    model_reset();

    // Reset overrides sync and load; settle cycle stays silent
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 5, 3);
    step(0, 1, 0, 0, 0, 0);
    check("post_reset_quiet",
          {28'd0, s_ov, s_baud, s_mid, s_ack}, 32'd0);

    foreach (tbl[k]) begin
      load_div("tbl_ack", int'(tbl[k].d), 0);
      step(0, 1, 1, 0, 0, 0);
      t_s = tnow;
      t1 = -1; t2 = -1; tb1 = -1; tb2 = -1; tm = -1;
      for (int n = 0; n < 2 * OV * (tbl[k].d + 1) + 8; n++) begin
        step(0, 1, 0, 0, 0, 0);
        if (s_ov) begin
          if (t1 < 0) t1 = tnow; else if (t2 < 0) t2 = tnow;
        end
        if (s_baud) begin
          if (tb1 < 0) tb1 = tnow; else if (tb2 < 0) tb2 = tnow;
        end
        if (s_mid && tb1 >= 0 && tm < 0) tm = tnow;
      end
      check("tbl_ov_period", 32'(t2 - t1), 32'(tbl[k].ov_p));
      check("tbl_first_baud", 32'(tb1 - t_s), 32'(tbl[k].baud_p));
      check("tbl_baud_period", 32'(tb2 - tb1), 32'(tbl[k].baud_p));
      check("tbl_mid_offset", 32'(tm - tb1), 32'(tbl[k].mid_off));
    end

    // Load mid-period: old period completes, ack at wrap
    load_div("reload_ack3", 3, 0);
    step(0, 1, 1, 0, 0, 0);
    t_s = tnow;
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 7, 0);
    t_l = tnow;
    t1 = -1; t2 = -1; ta = -1;
    for (int n = 0; n < 20; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_ov) begin
        if (t1 < 0) t1 = tnow; else if (t2 < 0) t2 = tnow;
      end
      if (s_ack && ta < 0) ta = tnow;
    end
    check("reload_old_period", 32'(t1 - t_s), 32'd4);
    check("reload_tick_pos", 32'(t1 - t_l), 32'd2);
    check("reload_ack_at_wrap", 32'(ta), 32'(t1));
    check("reload_new_period", 32'(t2 - t1), 32'd8);

    // Sync at sub=10 restarts the bit phase
    load_div("sync_ack", 3, 0);
    step(0, 1, 1, 0, 0, 0);
    cnt = 0;
    for (int n = 0; n < 200 && cnt < 10; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_ov) cnt++;
    end
    check("sync_reach_sub10", 32'(cnt), 32'd10);
    step(0, 1, 1, 0, 0, 0);
    t_s = tnow;
    check("sync_no_tick", 32'(s_ov | s_baud | s_mid), 32'd0);
    tb1 = -1; tm = -1;
    for (int n = 0; n < 70; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_baud && tb1 < 0) tb1 = tnow;
      if (s_mid && tm < 0) tm = tnow;
    end
    check("sync_baud_delay", 32'(tb1 - t_s), 32'd64);
    check("sync_mid_delay", 32'(tm - t_s), 32'd32);

    // D=0 with a 5-cycle enable gap
    load_div("d0_ack", 0, 0);
    step(0, 1, 1, 0, 0, 0);
    t_s = tnow;
    for (int n = 0; n < 7; n++) step(0, 1, 0, 0, 0, 0);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      step(0, 0, 0, 0, 0, 0);
      cnt += int'(s_ov) + int'(s_baud) + int'(s_mid);
    end
    check("d0_gap_quiet", 32'(cnt), 32'd0);
    tb1 = -1;
    for (int n = 0; n < 20 && tb1 < 0; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_baud) tb1 = tnow;
    end
    check("d0_phase_kept", 32'(tb1 - t_s), 32'd21);

`ifdef FRAC_BAUD_FRAC_DIV_EN
    load_div("frac_ack", 3, 8);
    step(0, 1, 1, 0, 0, 0);
    cnt = 0; t1 = -1; t2 = -1;
    for (int n = 0; n < 120 && cnt < 17; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_ov) begin
        cnt++;
        if (cnt == 1) t1 = tnow;
        if (cnt == 17) t2 = tnow;
      end
    end
    check("frac_16_ticks_span", 32'(t2 - t1), 32'd72);
`endif

    // Reset with a pending load: no ack, reset divisor in force
    load_div("rst_ack", 3, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 9, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 2, 0);
    check("rst_outputs_low",
          {28'd0, s_ov, s_baud, s_mid, s_ack}, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    t_p = tnow;
    check("rst_after_low",
          {28'd0, s_ov, s_baud, s_mid, s_ack}, 32'd0);
    n_ack = 0; t1 = -1;
    for (int n = 0; n < 340; n++) begin
      step(0, 1, 0, 0, 0, 0);
      if (s_ack) n_ack++;
      if (s_ov && t1 < 0) t1 = tnow;
    end
    check("rst_no_ack", 32'(n_ack), 32'd0);
    check("rst_div_period", 32'(t1 - t_p), 32'(RDIV + 1));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 5)),
           int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frac_baud_generator.md
FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

Interface
REQ-001 SHALL have parameter DIV_W, 16, width of integer divisor and oversample counter.
REQ-002 SHALL have parameter FRAC_W, 4, width of fractional divisor and phase accumulator.
REQ-003 SHALL have parameter OVS, 16, oversample ticks per baud period, even, >= 4.
REQ-004 SHALL have parameter RESET_DIV, 16'd325, integer divisor in force after reset.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i input 1, sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_i input 1, synchronous active-high reset.
REQ-008 SHALL have port enable_i input 1, counting enable.
REQ-009 SHALL have port sync_i input 1, phase restart strobe (RX start-bit alignment).
REQ-010 SHALL have port div_load_i input 1, one-cycle strobe capturing new divisor.
REQ-011 SHALL have port divisor_int_i input DIV_W, integer divisor D.
REQ-012 SHALL have port divisor_frac_i input FRAC_W, fractional divisor F (F/2^FRAC_W).
REQ-013 SHALL have port ov_tick_o output 1, oversample tick, one cycle wide.
REQ-014 SHALL have port baud_tick_o output 1, bit-rate tick, one cycle wide.
REQ-015 SHALL have port mid_bit_o output 1, bit-centre tick, one cycle wide.
REQ-016 SHALL have port div_ack_o output 1, one-cycle pulse when a loaded divisor takes effect.

Function
REQ-017 Oversample counter SHALL count 0..T then wrap to 0, T = active D, or D+1 when stretch flag set; ov_tick_o high in cycle counter==T and enable_i high.
REQ-018 Oversample period SHALL be D+1 cycles (D+2 when stretched); D=0 gives ov_tick_o every enabled cycle.
REQ-019 On each ov tick, accumulator SHALL update acc <= acc + F modulo 2^FRAC_W; carry-out sets stretch flag for the next period only.
REQ-020 Baud sub-counter SHALL count ov ticks 0..OVS-1, wrapping; baud_tick_o = ov tick AND sub==OVS-1.
REQ-021 mid_bit_o SHALL equal ov tick AND sub==OVS/2-1.
REQ-022 div_load_i SHALL capture divisor_int_i/divisor_frac_i into a shadow and set pending; a second load while pending overwrites shadow.
REQ-023 Pending shadow SHALL become active at the ov-tick wrap cycle (or the next cycle if enable_i low), clearing pending and pulsing div_ack_o that cycle.
REQ-024 sync_i SHALL zero oversample counter, sub-counter, accumulator and stretch flag; no tick outputs in that cycle; pending load unaffected.
REQ-025 sync_i SHALL take priority over enable_i and the tick condition in the same cycle.
REQ-026 enable_i low SHALL freeze all counters and force ov_tick_o, baud_tick_o, mid_bit_o low.
REQ-027 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except enable_i gating.

Reset
REQ-028 rst_i SHALL zero counters, accumulator, stretch, pending; active and shadow D=RESET_DIV, F=0.
REQ-029 All outputs SHALL be 0 during and the cycle after reset; reset overrides sync_i and div_load_i.

Configuration
REQ-030 Macro FRAC_BAUD_FRAC_DIV_EN SHALL compile in accumulator, stretch flag and use of divisor_frac_i.
REQ-031 Without FRAC_BAUD_FRAC_DIV_EN, divisor_frac_i SHALL be ignored, T=D always, port list unchanged.

Structure
REQ-032 Shared package uart_pkg SHALL hold divisor typedefs, DIV_W/FRAC_W/OVS defaults and RESET_DIV.
REQ-033 Sub-module frac_baud_accum SHALL hold accumulator and stretch logic, instantiated only under the macro.

Verification
REQ-034 D=3, F=0, enable high: ov_tick_o every 4 cycles, baud_tick_o every 64, mid_bit_o 32 cycles after each baud_tick_o.
REQ-035 Macro on, D=3, F=8, FRAC_W=4: ov periods alternate 4,5 cycles; 16 ov ticks span 72 cycles.
REQ-036 Load D=7 at counter=1 of D=3 period: old period completes (4 cycles), div_ack_o at wrap, next period 8 cycles.
REQ-037 sync_i at sub=10: no tick that cycle, next baud_tick_o exactly 16x(D+1) cycles later, mid_bit_o at 8x(D+1).
REQ-038 D=0: ov_tick_o every cycle; enable_i low 5 cycles mid-stream: outputs low, phase resumes unchanged.
REQ-039 rst_i asserted mid-period with pending load: outputs 0, active D=RESET_DIV, no div_ack_o afterwards.
